// File: rtl/viterbi_ber_checker.sv
// BER monitor: finds the source-to-decoded latency, locks to it, then counts compared bits and errors.
// Outputs are registered one edge after the sample; one compare per clock, no backpressure.
module viterbi_ber_checker #(
    parameter int MAX_LAT     = 64,
    parameter int LOCK_LEN    = 32,
    parameter int WIN         = 64,
    parameter int LOSS_THRESH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ref_bit_i,
    input  logic                       ref_valid_i,
    input  logic                       dec_bit_i,
    input  logic                       dec_valid_i,
    input  logic                       clear_i,
    output logic                       locked_o,
    output logic [$clog2(MAX_LAT)-1:0] lat_o,
    output logic [31:0]                bit_cnt_o,
    output logic [31:0]                err_cnt_o,
    output logic                       err_pulse_o,
    output logic [7:0]                 relock_cnt_o
);

    localparam int LW = $clog2(MAX_LAT);
    localparam int FW = $clog2(MAX_LAT + 1);
    localparam int MW = $clog2(LOCK_LEN + 1);
    localparam int WW = $clog2(WIN + 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [MAX_LAT-1:0] hist;
    logic [FW-1:0]      fill_cnt;
    logic [LW-1:0]      cand;
    logic [MW-1:0]      match_cnt;
    logic [WW-1:0]      win_bits;
    logic [WW-1:0]      win_errs;

    logic          cmp_en;
    logic          srch_cmp;
    logic          srch_hit;
    logic          lock_cmp;
    logic          lock_err;
    logic          lock_hit;
    logic          win_done;
    logic          win_fail;
    logic [MW-1:0] match_nxt;
    logic [WW-1:0] win_bits_nxt;
    logic [WW-1:0] win_errs_nxt;

    // All compares look at the history as it was before this edge's shift.
    always_comb begin
        cmp_en       = dec_valid_i && (fill_cnt != '0);
        srch_cmp     = (state == SEARCH) && cmp_en && (FW'(cand) < fill_cnt);
        srch_hit     = (dec_bit_i == hist[cand]);
        lock_cmp     = (state == LOCKED) && cmp_en;
        lock_err     = (dec_bit_i != hist[lat_o]);
        match_nxt    = match_cnt + MW'(1);
        win_bits_nxt = win_bits + WW'(1);
        win_errs_nxt = win_errs + WW'(lock_err);
        lock_hit     = srch_cmp && srch_hit && (match_nxt == MW'(LOCK_LEN));
        win_done     = lock_cmp && (win_bits_nxt == WW'(WIN));
        win_fail     = win_done && (win_errs_nxt > WW'(LOSS_THRESH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SEARCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SEARCH:  if (lock_hit) state_nxt = LOCKED;
            LOCKED:  if (win_fail) state_nxt = SEARCH;
            default: state_nxt = SEARCH;
        endcase
    end

    always_comb begin
        locked_o = (state == LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist         <= '0;
            fill_cnt     <= '0;
            cand         <= '0;
            match_cnt    <= '0;
            lat_o        <= '0;
            win_bits     <= '0;
            win_errs     <= '0;
            bit_cnt_o    <= '0;
            err_cnt_o    <= '0;
            err_pulse_o  <= 1'b0;
            relock_cnt_o <= '0;
        end else begin
            if (ref_valid_i) begin
                hist <= {hist[MAX_LAT-2:0], ref_bit_i};
                if (fill_cnt != FW'(MAX_LAT)) fill_cnt <= fill_cnt + FW'(1);
            end

            if (srch_cmp) begin
                if (srch_hit) begin
                    match_cnt <= match_nxt;
                    if (lock_hit) begin
                        lat_o    <= cand;
                        win_bits <= '0;
                        win_errs <= '0;
                    end
                end else begin
                    match_cnt <= '0;
                    cand      <= cand + LW'(1);
                end
            end

            if (lock_cmp) begin
                if (win_done) begin
                    win_bits <= '0;
                    win_errs <= '0;
                    if (win_fail) begin
                        cand      <= lat_o + LW'(1);
                        match_cnt <= '0;
                    end
                end else begin
                    win_bits <= win_bits_nxt;
                    win_errs <= win_errs_nxt;
                end
            end

            // Clear wins over same-cycle increments; window/lock logic above is unaffected.
            err_pulse_o <= 1'b0;
            if (clear_i) begin
                bit_cnt_o    <= '0;
                err_cnt_o    <= '0;
                relock_cnt_o <= '0;
            end else if (lock_cmp) begin
                if (bit_cnt_o != '1) bit_cnt_o <= bit_cnt_o + 32'd1;
                if (lock_err) begin
                    if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 32'd1;
                    err_pulse_o <= 1'b1;
                end
                if (win_fail && relock_cnt_o != '1) relock_cnt_o <= relock_cnt_o + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Bench for viterbi_ber_checker: PRBS7 source, delayed/corrupted decoded stream, queue-based reference model.
module tb_viterbi_ber_checker;

    localparam int MAX_LAT     = 64;
    localparam int LOCK_LEN    = 32;
    localparam int WIN         = 64;
    localparam int LOSS_THRESH = 16;
    localparam longint CMAX    = 64'hFFFF_FFFF;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ref_bit_i = 1'b0, ref_valid_i = 1'b0;
    logic       dec_bit_i = 1'b0, dec_valid_i = 1'b0;
    logic       clear_i = 1'b0;
    logic       locked_o;
    logic [5:0] lat_o;
    logic [31:0] bit_cnt_o, err_cnt_o;
    logic       err_pulse_o;
    logic [7:0] relock_cnt_o;

    viterbi_ber_checker #(
        .MAX_LAT(MAX_LAT), .LOCK_LEN(LOCK_LEN), .WIN(WIN), .LOSS_THRESH(LOSS_THRESH)
    ) dut (
        .clk(clk), .rst(rst),
        .ref_bit_i(ref_bit_i), .ref_valid_i(ref_valid_i),
        .dec_bit_i(dec_bit_i), .dec_valid_i(dec_valid_i),
        .clear_i(clear_i),
        .locked_o(locked_o), .lat_o(lat_o),
        .bit_cnt_o(bit_cnt_o), .err_cnt_o(err_cnt_o),
        .err_pulse_o(err_pulse_o), .relock_cnt_o(relock_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Stimulus state: all source bits accepted so far (oldest first) and the decoder delay,
    // where delay D means the decoded bit equals the source bit D places behind the newest one.
    logic [6:0] lfsr = 7'h7F;
    bit   sent[$];
    int   delay = 10;
    int   dut_pulses = 0;
    int   mdl_pulses = 0;

    // Reference model state (history newest-first in a queue).
    bit     hq[$];
    bit     m_locked;
    int     m_lat, m_cand, m_match, m_wb, m_we;
    longint m_bits, m_errs;
    int     m_relock;
    bit     m_pulse;

    task automatic model_reset();
        hq.delete();
        m_locked = 0; m_lat = 0; m_cand = 0; m_match = 0; m_wb = 0; m_we = 0;
        m_bits = 0; m_errs = 0; m_relock = 0; m_pulse = 0;
    endtask

    task automatic model_step(input bit rv, input bit rb, input bit dv, input bit db, input bit clr);
        bit err;
        m_pulse = 0;
        if (dv && hq.size() > 0) begin
            if (!m_locked) begin
                if (m_cand < hq.size()) begin
                    if (db == hq[m_cand]) begin
                        m_match++;
                        if (m_match == LOCK_LEN) begin
                            m_locked = 1; m_lat = m_cand; m_wb = 0; m_we = 0;
                        end
                    end else begin
                        m_match = 0;
                        m_cand = (m_cand + 1) % MAX_LAT;
                    end
                end
            end else begin
                err = (db != hq[m_lat]);
                if (!clr) begin
                    if (m_bits < CMAX) m_bits++;
                    if (err) begin
                        if (m_errs < CMAX) m_errs++;
                        m_pulse = 1;
                    end
                end
                m_wb++;
                if (err) m_we++;
                if (m_wb == WIN) begin
                    if (m_we > LOSS_THRESH) begin
                        m_locked = 0;
                        m_cand = (m_lat + 1) % MAX_LAT;
                        m_match = 0;
                        if (!clr && m_relock < 255) m_relock++;
                    end
                    m_wb = 0; m_we = 0;
                end
            end
        end
        if (clr) begin m_bits = 0; m_errs = 0; m_relock = 0; end
        if (rv) begin
            hq.push_front(rb);
            if (hq.size() > MAX_LAT) void'(hq.pop_back());
        end
    endtask

    // One clock of stimulus: inputs set at the falling edge, model advanced at the rising edge.
    task automatic drive(input bit rv, input bit dv, input bit flip, input bit clr);
        bit rb, db, dve, nb;
        dve = dv && (sent.size() > delay);
        db  = dve ? (sent[sent.size() - 1 - delay] ^ flip) : 1'b0;
        rb  = 1'b0;
        if (rv) begin
            nb   = lfsr[6] ^ lfsr[5];
            lfsr = {lfsr[5:0], nb};
            rb   = nb;
        end
        ref_valid_i = rv; ref_bit_i = rb;
        dec_valid_i = dve; dec_bit_i = db;
        clear_i = clr;
        @(posedge clk);
        model_step(rv, rb, dve, db, clr);
        if (rv) sent.push_back(rb);
        @(negedge clk);
        if (err_pulse_o) dut_pulses++;
        if (m_pulse) mdl_pulses++;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(negedge clk);
        checks++; if (locked_o !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked_o); end
        checks++; if (lat_o !== 6'd0) begin failures++; $display("FAIL reset_lat got=%0d exp=0", lat_o); end
        checks++; if (bit_cnt_o !== 32'd0) begin failures++; $display("FAIL reset_bits got=%0d exp=0", bit_cnt_o); end
        checks++; if (err_cnt_o !== 32'd0) begin failures++; $display("FAIL reset_errs got=%0d exp=0", err_cnt_o); end
        checks++; if (err_pulse_o !== 1'b0) begin failures++; $display("FAIL reset_pulse got=%b exp=0", err_pulse_o); end
        checks++; if (relock_cnt_o !== 8'd0) begin failures++; $display("FAIL reset_relock got=%0d exp=0", relock_cnt_o); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lock_clean();
        delay = 10;
        for (int i = 0; i < 2000 && !locked_o; i++) drive(1, 1, 0, 0);
        checks++; if (locked_o !== 1'b1) begin failures++; $display("FAIL clean_locked got=%b exp=1", locked_o); end
        checks++; if (lat_o !== 6'd10) begin failures++; $display("FAIL clean_lat got=%0d exp=10", lat_o); end
        checks++; if (m_locked !== 1'b1 || lat_o !== 6'(m_lat)) begin failures++; $display("FAIL clean_model_lock got=%0d/%b model=%0d/%b", lat_o, locked_o, m_lat, m_locked); end
        for (int i = 0; i < 1000; i++) drive(1, 1, 0, 0);
        checks++; if (bit_cnt_o !== 32'd1000) begin failures++; $display("FAIL clean_bits got=%0d exp=1000", bit_cnt_o); end
        checks++; if (err_cnt_o !== 32'd0) begin failures++; $display("FAIL clean_errs got=%0d exp=0", err_cnt_o); end
    endtask

    task automatic test_sparse_errors();
        dut_pulses = 0; mdl_pulses = 0;
        for (int i = 0; i < 1024; i++) drive(1, 1, (i % 16) == 15, 0);
        checks++; if (err_cnt_o !== 32'd64) begin failures++; $display("FAIL sparse_errs got=%0d exp=64", err_cnt_o); end
        checks++; if (dut_pulses != 64) begin failures++; $display("FAIL sparse_pulses got=%0d exp=64", dut_pulses); end
        checks++; if (dut_pulses != mdl_pulses) begin failures++; $display("FAIL sparse_pulses_model got=%0d model=%0d", dut_pulses, mdl_pulses); end
        checks++; if (locked_o !== 1'b1) begin failures++; $display("FAIL sparse_locked got=%b exp=1", locked_o); end
        checks++; if (relock_cnt_o !== 8'd0) begin failures++; $display("FAIL sparse_relock got=%0d exp=0", relock_cnt_o); end
        checks++; if (bit_cnt_o !== 32'(m_bits)) begin failures++; $display("FAIL sparse_bits got=%0d model=%0d", bit_cnt_o, m_bits); end
    endtask

    task automatic test_clear();
        drive(1, 1, 0, 1);
        for (int i = 0; i < 500; i++) drive(1, 1, 0, 0);
        checks++; if (bit_cnt_o !== 32'd500) begin failures++; $display("FAIL clear_pre_bits got=%0d exp=500", bit_cnt_o); end
        // The clearing cycle carries a corrupted bit that must not be counted or pulsed.
        drive(1, 1, 1, 1);
        checks++; if (bit_cnt_o !== 32'd0) begin failures++; $display("FAIL clear_bits got=%0d exp=0", bit_cnt_o); end
        checks++; if (err_cnt_o !== 32'd0) begin failures++; $display("FAIL clear_errs got=%0d exp=0", err_cnt_o); end
        checks++; if (err_pulse_o !== 1'b0) begin failures++; $display("FAIL clear_pulse got=%b exp=0", err_pulse_o); end
        checks++; if (relock_cnt_o !== 8'd0) begin failures++; $display("FAIL clear_relock got=%0d exp=0", relock_cnt_o); end
        checks++; if (locked_o !== 1'b1) begin failures++; $display("FAIL clear_locked got=%b exp=1", locked_o); end
    endtask

    task automatic test_loss_reacquire();
        for (int i = 0; i < WIN && m_wb != 0; i++) drive(1, 1, 0, 0);
        for (int i = 0; i < WIN - 1; i++) drive(1, 1, i < 20, 0);
        checks++; if (locked_o !== 1'b1) begin failures++; $display("FAIL loss_early_drop got=%b exp=1", locked_o); end
        drive(1, 1, 0, 0);
        checks++; if (locked_o !== 1'b0) begin failures++; $display("FAIL loss_locked got=%b exp=0", locked_o); end
        checks++; if (relock_cnt_o !== 8'd1) begin failures++; $display("FAIL loss_relock got=%0d exp=1", relock_cnt_o); end
        delay = 12;
        for (int i = 0; i < 3000 && !locked_o; i++) drive(1, 1, 0, 0);
        checks++; if (locked_o !== 1'b1) begin failures++; $display("FAIL reacq_locked got=%b exp=1", locked_o); end
        checks++; if (lat_o !== 6'd12) begin failures++; $display("FAIL reacq_lat got=%0d exp=12", lat_o); end
        checks++; if (relock_cnt_o !== 8'(m_relock)) begin failures++; $display("FAIL reacq_relock got=%0d model=%0d", relock_cnt_o, m_relock); end
    endtask

    task automatic test_reset_mid_lock();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if ({locked_o, lat_o, bit_cnt_o, err_cnt_o, err_pulse_o, relock_cnt_o} !== '0) begin
            failures++; $display("FAIL midreset_outputs locked=%b lat=%0d bits=%0d errs=%0d pulse=%b relock=%0d exp=all0",
                                 locked_o, lat_o, bit_cnt_o, err_cnt_o, err_pulse_o, relock_cnt_o); end
        model_reset();
        sent.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3000 && !locked_o; i++) drive(1, 1, 0, 0);
        checks++; if (locked_o !== 1'b1) begin failures++; $display("FAIL midreset_relock got=%b exp=1", locked_o); end
        checks++; if (lat_o !== 6'd12) begin failures++; $display("FAIL midreset_lat got=%0d exp=12", lat_o); end
    endtask

    task automatic test_sparse_valid();
        rst = 1'b1;
        model_reset();
        sent.delete();
        @(negedge clk);
        rst = 1'b0;
        delay = 5;
        dut_pulses = 0; mdl_pulses = 0;
        for (int i = 0; i < 6000 && !locked_o; i++) drive($urandom_range(0, 1), $urandom_range(0, 1), 0, 0);
        checks++; if (locked_o !== 1'b1) begin failures++; $display("FAIL svalid_locked got=%b exp=1", locked_o); end
        checks++; if (lat_o !== 6'd5) begin failures++; $display("FAIL svalid_lat got=%0d exp=5", lat_o); end
        for (int i = 0; i < 600; i++) drive($urandom_range(0, 1), $urandom_range(0, 1), 0, 0);
        checks++; if (err_cnt_o !== 32'd0) begin failures++; $display("FAIL svalid_errs got=%0d exp=0", err_cnt_o); end
        checks++; if (bit_cnt_o !== 32'(m_bits)) begin failures++; $display("FAIL svalid_bits got=%0d model=%0d", bit_cnt_o, m_bits); end
        checks++; if (dut_pulses != 0) begin failures++; $display("FAIL svalid_pulses got=%0d exp=0", dut_pulses); end
    endtask

    initial begin
        test_reset();
        test_lock_clean();
        test_sparse_errors();
        test_clear();
        test_loss_reacquire();
        test_reset_mid_lock();
        test_sparse_valid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/viterbi_ber_checker.md
# viterbi_ber_checker

Downstream bit-error-rate monitor for the Viterbi link. It consumes the decoded bit stream and the original source bits that were fed into the convolutional encoder. It automatically finds the encoder-to-decoder latency and locks to it. Once locked, it counts compared bits and residual errors so the bench and lab firmware can measure decoder performance under injected channel errors.

## Interface
Parameters:
- MAX_LAT, 64: depth of the source-bit history. Candidate latencies are 0..MAX_LAT-1. Power of two.
- LOCK_LEN, 32: consecutive matches at one candidate latency required to declare lock.
- WIN, 64: size of the loss-of-lock window, in compared bits.
- LOSS_THRESH, 16: loss of lock occurs when a window holds more than this many errors.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- ref_bit_i  in  1  source bit presented to the encoder.
- ref_valid_i  in  1  ref_bit_i is valid this cycle (the encoder enable).
- dec_bit_i  in  1  decoded bit from the Viterbi decoder.
- dec_valid_i  in  1  dec_bit_i is valid this cycle.
- clear_i  in  1  synchronous clear of bit_cnt_o, err_cnt_o and relock_cnt_o. Lock state is kept.
- locked_o  out  1  checker is locked to lat_o.
- lat_o  out  $clog2(MAX_LAT)  locked latency, counted in ref_valid_i samples.
- bit_cnt_o  out  32  bits compared while locked. Saturates at 2^32-1.
- err_cnt_o  out  32  mismatches while locked. Saturates at 2^32-1.
- err_pulse_o  out  1  one-cycle pulse for each mismatch counted while locked.
- relock_cnt_o  out  8  number of loss-of-lock events. Saturates at 255.

## Operation
- History register hist[0..MAX_LAT-1], where hist[0] is the newest bit.
  - On ref_valid_i, hist shifts by one and ref_bit_i enters hist[0].
  - fill_cnt counts shifts and saturates at MAX_LAT.
- Every comparison uses the pre-update hist value. If ref_valid_i and dec_valid_i occur in the same cycle, the compare sees the old hist and the shift happens at that same edge.
- State machine has two states: SEARCH and LOCKED. Reset enters SEARCH with cand=0 and match_cnt=0.
- SEARCH, on each dec_valid_i:
  - If cand >= fill_cnt: skip the compare; no state change.
  - Else if dec_bit_i == hist[cand]: match_cnt increments. When match_cnt reaches LOCK_LEN, go to LOCKED, set lat_o=cand, and clear win_bits and win_errs.
  - Else (mismatch): match_cnt=0 and cand increments, wrapping from MAX_LAT-1 to 0.
- LOCKED, on each dec_valid_i:
  - Compare dec_bit_i with hist[lat_o].
  - bit_cnt_o increments (saturating), and win_bits increments.
  - On a mismatch, err_cnt_o increments (saturating), win_errs increments, and err_pulse_o=1 for one cycle.
  - When win_bits reaches WIN:
    - If win_errs > LOSS_THRESH: go to SEARCH, increment relock_cnt_o (saturating), and set cand=lat_o+1 (wrapping) with match_cnt=0.
    - Otherwise, clear win_bits and win_errs and stay LOCKED.
  - The compare that completes a window is included in that window's win_errs.
- SEARCH compares never change bit_cnt_o, err_cnt_o or err_pulse_o.
- clear_i has priority over increments in the same cycle. The counters read 0 on the next cycle, and that cycle's compare is discarded from the counters only. Window and lock logic still process it.
- dec_valid_i with no prior ref data (fill_cnt=0) is ignored in both states.

## Timing
- All outputs are registered.
- Reset values: locked_o=0, lat_o=0, bit_cnt_o=0, err_cnt_o=0, err_pulse_o=0, relock_cnt_o=0. hist, fill_cnt, cand, match_cnt and the window counters are all cleared.
- locked_o rises on the edge that processes the LOCK_LEN-th consecutive match. lat_o is valid on that same edge.
- Counter and err_pulse_o updates appear one edge after the dec_valid_i sample that produced them.
- locked_o falls on the edge that closes a failing window.
- Asserting rst mid-lock clears everything immediately (asynchronously). After release, the checker re-acquires lock from cand=0.
- Throughput: one compare per clock. No backpressure; dec_valid_i may be asserted on every cycle.

## Test plan
- Lock, clean link: PRBS7 on ref, dec equals ref delayed by 10 valid samples, both valid every cycle, defaults. Required: lat_o=10, locked_o high, then 1000 further bits give bit_cnt_o=1000 and err_cnt_o=0.
- Sparse errors: locked at latency 10, flip 1 dec bit in every 16 for 1024 bits. Required: err_cnt_o=64, 64 err_pulse_o pulses, locked_o stays 1, relock_cnt_o=0.
- Loss and reacquire: locked at 10, then 20 flipped bits inside one 64-bit window, then change the delay to 12. Required: locked_o drops at that window's end, relock_cnt_o=1, and a relock at lat_o=12.
- Simultaneous valid and sparse valid: ref_valid_i and dec_valid_i asserted on random cycles (each 50%) with a fixed sample delay of 5. Required: lat_o=5 and err_cnt_o=0.
- clear_i while locked with bit_cnt_o=500: counters read 0 on the next cycle and locked_o stays 1.
- Reset mid-lock: assert rst while locked. Required: all outputs 0 on the same cycle; after release, lock is reacquired at the same latency.
